// File: rtl/mod_settings_loader_if.sv
// Read port between the settings loader and the controller BRAM.
// The loader is the master: it drives strobe and address and receives read data.
interface mod_settings_loader_if;
    logic        rd_en;
    logic [7:0]  addr;
    logic [15:0] dout;

    modport master (output rd_en, output addr, input dout);
    modport slave  (input rd_en, input addr, output dout);
endinterface

// File: rtl/mod_settings_loader.sv
// Polls the controller BRAM flag word and, on a rising MOD_SET bit, burst-loads the
// modulation register block into a shadow set, validates it and commits it atomically.
//
// state       | meaning
// ------------+----------------------------------------------------------------
// S_POLL      | strobe the flag word (the first cycle after reset only arms the strobe)
// S_WAIT_FLAG | wait out the BRAM latency, then sample MOD_SET and detect its rising edge
// S_LOAD      | issue the 13 block addresses on consecutive cycles
// S_DRAIN     | let the last reads land in the shadow set
// S_CHECK     | validate the shadow set; commit with UPDATE or reject with ERR
module mod_settings_loader #(
    parameter int BramLatency = 2,
    parameter int FreqDivMin  = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    mod_settings_loader_if.master bram,
    output logic                  mem_wr_segment_o,
    output logic                  req_rd_segment_o,
    output logic [15:0]           cycle0_o,
    output logic [15:0]           cycle1_o,
    output logic [15:0]           freq_div0_o,
    output logic [15:0]           freq_div1_o,
    output logic [15:0]           rep0_o,
    output logic [15:0]           rep1_o,
    output logic [7:0]            transition_mode_o,
    output logic [63:0]           transition_value_o,
    output logic                  update_o,
    output logic                  err_o
);

    typedef logic [7:0] bram_addr_t;

    localparam bram_addr_t ADDR_CTL_FLAG        = 8'h00;
    localparam int         CTL_FLAG_BIT_MOD_SET = 0;
    localparam bram_addr_t ADDR_MOD_BASE        = 8'h20;
    localparam int         N_WORDS              = 13;

    localparam logic [3:0] IDX_MEM_WR_SEGMENT  = 4'd0;
    localparam logic [3:0] IDX_REQ_RD_SEGMENT  = 4'd1;
    localparam logic [3:0] IDX_CYCLE0          = 4'd2;
    localparam logic [3:0] IDX_FREQ_DIV0       = 4'd3;
    localparam logic [3:0] IDX_REP0            = 4'd4;
    localparam logic [3:0] IDX_CYCLE1          = 4'd5;
    localparam logic [3:0] IDX_FREQ_DIV1       = 4'd6;
    localparam logic [3:0] IDX_REP1            = 4'd7;
    localparam logic [3:0] IDX_TRANSITION_MODE = 4'd8;
    localparam logic [3:0] IDX_VALUE_0         = 4'd9;
    localparam logic [3:0] IDX_VALUE_1         = 4'd10;
    localparam logic [3:0] IDX_VALUE_2         = 4'd11;
    localparam logic [3:0] IDX_VALUE_3         = 4'd12;

    localparam logic [3:0]  LAT_M1        = 4'(BramLatency - 1);
    localparam logic [3:0]  LOAD_M1       = 4'(N_WORDS - 1);
    localparam int          CAP_LAST      = BramLatency - 1;
    localparam logic [15:0] FREQ_DIV_RST  = 16'd10;
    localparam logic [15:0] REP_RST       = 16'hFFFF;
    localparam logic [15:0] FREQ_DIV_MIN  = 16'(FreqDivMin);

    typedef enum logic [2:0] {
        S_POLL,
        S_WAIT_FLAG,
        S_LOAD,
        S_DRAIN,
        S_CHECK
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       rd_en_q;
    bram_addr_t addr_q;
    logic       flag_prev_q;
    logic       update_q;
    logic       err_q;

    logic        mem_wr_segment_q;
    logic        req_rd_segment_q;
    logic [15:0] cycle0_q;
    logic [15:0] cycle1_q;
    logic [15:0] freq_div0_q;
    logic [15:0] freq_div1_q;
    logic [15:0] rep0_q;
    logic [15:0] rep1_q;
    logic [7:0]  transition_mode_q;
    logic [63:0] transition_value_q;

    logic        sh_mem_wr_segment_q;
    logic        sh_req_rd_segment_q;
    logic [15:0] sh_cycle0_q;
    logic [15:0] sh_cycle1_q;
    logic [15:0] sh_freq_div0_q;
    logic [15:0] sh_freq_div1_q;
    logic [15:0] sh_rep0_q;
    logic [15:0] sh_rep1_q;
    logic [7:0]  sh_transition_mode_q;
    logic [63:0] sh_transition_value_q;

    // Issue tags travel alongside the BRAM pipeline so each word lands by its own index.
    logic       cap_vld_q [BramLatency];
    logic [3:0] cap_idx_q [BramLatency];

    logic flag_now;
    logic mode_legal;
    logic shadow_valid;

    assign flag_now   = bram.dout[CTL_FLAG_BIT_MOD_SET];
    assign mode_legal = (sh_transition_mode_q == 8'h00) || (sh_transition_mode_q == 8'h01) ||
                        (sh_transition_mode_q == 8'h02) || (sh_transition_mode_q == 8'hF0);
    assign shadow_valid = (sh_freq_div0_q >= FREQ_DIV_MIN) &&
                          (sh_freq_div1_q >= FREQ_DIV_MIN) && mode_legal;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < BramLatency; i++) begin
                cap_vld_q[i] <= 1'b0;
                cap_idx_q[i] <= 4'd0;
            end
            sh_mem_wr_segment_q   <= 1'b0;
            sh_req_rd_segment_q   <= 1'b0;
            sh_cycle0_q           <= 16'd0;
            sh_cycle1_q           <= 16'd0;
            sh_freq_div0_q        <= 16'd0;
            sh_freq_div1_q        <= 16'd0;
            sh_rep0_q             <= 16'd0;
            sh_rep1_q             <= 16'd0;
            sh_transition_mode_q  <= 8'd0;
            sh_transition_value_q <= 64'd0;
        end else begin
            cap_vld_q[0] <= (state_q == S_LOAD);
            cap_idx_q[0] <= 4'(addr_q - ADDR_MOD_BASE);
            for (int i = 1; i < BramLatency; i++) begin
                cap_vld_q[i] <= cap_vld_q[i-1];
                cap_idx_q[i] <= cap_idx_q[i-1];
            end
            if (cap_vld_q[CAP_LAST]) begin
                unique case (cap_idx_q[CAP_LAST])
                    IDX_MEM_WR_SEGMENT:  sh_mem_wr_segment_q          <= bram.dout[0];
                    IDX_REQ_RD_SEGMENT:  sh_req_rd_segment_q          <= bram.dout[0];
                    IDX_CYCLE0:          sh_cycle0_q                  <= bram.dout;
                    IDX_FREQ_DIV0:       sh_freq_div0_q               <= bram.dout;
                    IDX_REP0:            sh_rep0_q                    <= bram.dout;
                    IDX_CYCLE1:          sh_cycle1_q                  <= bram.dout;
                    IDX_FREQ_DIV1:       sh_freq_div1_q               <= bram.dout;
                    IDX_REP1:            sh_rep1_q                    <= bram.dout;
                    IDX_TRANSITION_MODE: sh_transition_mode_q         <= bram.dout[7:0];
                    IDX_VALUE_0:         sh_transition_value_q[15:0]  <= bram.dout;
                    IDX_VALUE_1:         sh_transition_value_q[31:16] <= bram.dout;
                    IDX_VALUE_2:         sh_transition_value_q[47:32] <= bram.dout;
                    IDX_VALUE_3:         sh_transition_value_q[63:48] <= bram.dout;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q            <= S_POLL;
            cnt_q              <= 4'd0;
            rd_en_q            <= 1'b0;
            addr_q             <= ADDR_CTL_FLAG;
            flag_prev_q        <= 1'b0;
            update_q           <= 1'b0;
            err_q              <= 1'b0;
            mem_wr_segment_q   <= 1'b0;
            req_rd_segment_q   <= 1'b0;
            cycle0_q           <= 16'd0;
            cycle1_q           <= 16'd0;
            freq_div0_q        <= FREQ_DIV_RST;
            freq_div1_q        <= FREQ_DIV_RST;
            rep0_q             <= REP_RST;
            rep1_q             <= REP_RST;
            transition_mode_q  <= 8'd0;
            transition_value_q <= 64'd0;
        end else begin
            update_q <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                S_POLL: begin
                    // Strobe is registered, so the first POLL after reset only arms it.
                    if (rd_en_q) begin
                        rd_en_q <= 1'b0;
                        cnt_q   <= LAT_M1;
                        state_q <= S_WAIT_FLAG;
                    end else begin
                        rd_en_q <= 1'b1;
                        addr_q  <= ADDR_CTL_FLAG;
                    end
                end
                S_WAIT_FLAG: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        flag_prev_q <= flag_now;
                        rd_en_q     <= 1'b1;
                        if (flag_now && !flag_prev_q) begin
                            addr_q  <= ADDR_MOD_BASE;
                            cnt_q   <= LOAD_M1;
                            state_q <= S_LOAD;
                        end else begin
                            addr_q  <= ADDR_CTL_FLAG;
                            state_q <= S_POLL;
                        end
                    end
                end
                S_LOAD: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q  <= cnt_q - 4'd1;
                        addr_q <= addr_q + 8'd1;
                    end else begin
                        rd_en_q <= 1'b0;
                        addr_q  <= ADDR_CTL_FLAG;
                        cnt_q   <= LAT_M1;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (shadow_valid) begin
                        mem_wr_segment_q   <= sh_mem_wr_segment_q;
                        req_rd_segment_q   <= sh_req_rd_segment_q;
                        cycle0_q           <= sh_cycle0_q;
                        cycle1_q           <= sh_cycle1_q;
                        freq_div0_q        <= sh_freq_div0_q;
                        freq_div1_q        <= sh_freq_div1_q;
                        rep0_q             <= sh_rep0_q;
                        rep1_q             <= sh_rep1_q;
                        transition_mode_q  <= sh_transition_mode_q;
                        transition_value_q <= sh_transition_value_q;
                        update_q           <= 1'b1;
                    end else begin
                        err_q <= 1'b1;
                    end
                    rd_en_q <= 1'b1;
                    addr_q  <= ADDR_CTL_FLAG;
                    state_q <= S_POLL;
                end
                default: begin
                    rd_en_q <= 1'b0;
                    addr_q  <= ADDR_CTL_FLAG;
                    state_q <= S_POLL;
                end
            endcase
        end
    end

    assign bram.rd_en = rd_en_q;
    assign bram.addr  = addr_q;

    assign mem_wr_segment_o   = mem_wr_segment_q;
    assign req_rd_segment_o   = req_rd_segment_q;
    assign cycle0_o           = cycle0_q;
    assign cycle1_o           = cycle1_q;
    assign freq_div0_o        = freq_div0_q;
    assign freq_div1_o        = freq_div1_q;
    assign rep0_o             = rep0_q;
    assign rep1_o             = rep1_q;
    assign transition_mode_o  = transition_mode_q;
    assign transition_value_o = transition_value_q;
    assign update_o           = update_q;
    assign err_o              = err_q;

endmodule
